freq_gauge_scheduler: RTL and testbench
=======================================

Name: freq_gauge_scheduler

Overview:
Time-multiplexes one shared frequency-measurement engine across NumChannels probe clocks. Runs entirely in ref_clk.
- Drives the external probe-clock mux select and the engine's measurement gate.
- Samples the engine's count, scales it to Hz and stores it per channel.
- Exposes results, an enable mask and status over an Avalon-MM slave with fixed read latency.

Parameters:
NumChannels, 4, number of probe channels (1..14)
ReferenceClock, 50000000, ref_clk frequency in Hz
MeasureCycles, ReferenceClock/100, gate-high window length in ref_clk cycles
SettleCycles, 64, cycles after a probe_sel change before the gate may rise
HoldCycles, ReferenceClock/1000, cycles after gate fall before count_in is sampled (engine CDC drain)
Multiplier, 100, scale from count to Hz (ReferenceClock/MeasureCycles)

Ports:
ref_clk  in  1  sole clock
reset  in  1  asynchronous, active-high
probe_sel  out  4  clock-mux select, channel index
gate  out  1  engine measurement window; high = count
count_in  in  32  engine count, already in ref_clk domain, stable by end of HOLD
mm_address  in  4  word address
mm_read  in  1  read strobe
mm_write  in  1  write strobe
mm_writedata  in  32  write data
mm_readdata  out  32  read data
mm_readdatavalid  out  1  read response strobe

Behaviour:
- Reset (async assert, state released on first ref_clk edge after deassert):
  - state=SELECT, channel=0, probe_sel=0, gate=0.
  - all results=0xFFFFFFFF (unmeasured), mask=all NumChannels bits set, sweep count=0.
  - mm_readdatavalid=0, mm_readdata=0.
- FSM:
  - SELECT: probe_sel=channel, gate=0, exactly SettleCycles cycles -> MEASURE.
  - MEASURE: gate=1 for exactly MeasureCycles cycles -> HOLD.
  - HOLD: gate=0 for exactly HoldCycles cycles -> STORE.
  - STORE: 1 cycle; result[channel] = count_in*Multiplier. Product is computed 64-bit wide; any value above 0xFFFFFFFE saturates to 0xFFFFFFFE, keeping 0xFFFFFFFF reserved for unmeasured. -> NEXT.
  - NEXT: 1 cycle; picks the next channel after the current one whose mask bit is set, round-robin with wrap. The current channel is eligible again only if it is the sole enabled one. Sweep count increments (8-bit wrap) when the index wraps or equals the previous one. Mask==0 -> IDLE, otherwise -> SELECT.
  - IDLE: gate=0, probe_sel holds. Leaves for NEXT the cycle after the mask becomes nonzero.
- probe_sel changes only on entry to SELECT. gate is registered, and never high outside MEASURE.
- Mask writes never abort a window in progress. The new mask is used at the next NEXT evaluation. Results of disabled channels are retained.
- Register map (word addresses):
  - 0..NumChannels-1: result, read-only.
  - NumChannels: control [NumChannels-1:0] enable mask, read/write; unused bits read 0.
  - NumChannels+1: status, read-only. [7:0] sweep count, [11:8] current channel, [31] busy (state != IDLE).
  - Other addresses: reads return 0, writes are ignored.
- Read latency is exactly 1 cycle: mm_readdatavalid pulses the cycle after mm_read, one response per read, no waitrequest.
- Read-during-STORE of the same result returns the pre-store value.
- mm_read and mm_write in the same cycle: the write is applied and the read returns the pre-write value.

Optional Feature:
FREQ_GAUGE_SCHED_IRQ_EN:
- Defined:
  - Adds output irq (1 bit) and status bit [30] sweep_done.
  - sweep_done is set on each sweep-count increment and is write-1-to-clear via a write to the status address.
  - irq = sweep_done & control[31]. control[31] is an IRQ enable, reset 0.
  - If a set event and a clear write coincide, set wins.
- Undefined: no irq port; status[30] and control[31] read 0 and writes to them are ignored.

Test Plan:
All scenarios use NumChannels=4, MeasureCycles=100, SettleCycles=4, HoldCycles=8, Multiplier=100.
1. Reset, then read addresses 0-5 -> 0xFFFFFFFF x4, control 0x0000000F, status busy=1 with channel 0. gate=0 and probe_sel=0 throughout reset.
2. Release reset with count_in=1234 -> gate rises 4 cycles later and stays high exactly 100 cycles. 8 cycles after gate falls, result0 reads 123400 (0x0001E208) with mm_readdatavalid exactly 1 cycle after mm_read.
3. Write mask 0xA -> after the current window completes, probe_sel sequence is 1,3,1,3. Sweep count increments once per 1->3->1 wrap.
4. count_in=0x03000000 at STORE -> result reads 0xFFFFFFFE (saturated). count_in=0 -> 0x00000000.
5. Write mask 0 during MEASURE -> gate stays high the full 100 cycles, result stored, then IDLE with gate=0 and busy=0. Write mask 0x1 -> SELECT of channel 0 starts 2 cycles later.
6. Assert reset mid-MEASURE -> gate=0 combinationally-asynchronously, all results 0xFFFFFFFF. With IRQ_EN defined and control[31]=1: irq asserts at the sweep end and clears after writing status with bit30=1.

Source files
------------

// File: rtl/freq_gauge_scheduler.sv
// freq_gauge_scheduler: shares one frequency-measurement engine across
// NumChannels probe clocks. It sequences mux select, settle, gate window,
// hold and store, scales counts to Hz and serves results over Avalon-MM.
// Optional macro FREQ_GAUGE_SCHED_IRQ_EN adds a sweep-done interrupt.
module freq_gauge_scheduler #(
   parameter int NumChannels    = 4,
   parameter int ReferenceClock = 50000000,
   parameter int MeasureCycles  = ReferenceClock / 100,
   parameter int SettleCycles   = 64,
   parameter int HoldCycles     = ReferenceClock / 1000,
   parameter int Multiplier     = 100
) (
   input  logic        ref_clk,
   input  logic        reset,
   output logic [3:0]  probe_sel,
   output logic        gate,
   input  logic [31:0] count_in,
   input  logic [3:0]  mm_address,
   input  logic        mm_read,
   input  logic        mm_write,
   input  logic [31:0] mm_writedata,
   output logic [31:0] mm_readdata,
   output logic        mm_readdatavalid
`ifdef FREQ_GAUGE_SCHED_IRQ_EN
   ,
   output logic        irq
`endif
);

   localparam int IdxW = (NumChannels > 1) ? $clog2(NumChannels) : 1;
   localparam logic [3:0] CtrlAddr = 4'(NumChannels);
   localparam logic [3:0] StatAddr = 4'(NumChannels + 1);

   typedef enum logic [2:0] {
      S_SELECT,
      S_MEASURE,
      S_HOLD,
      S_STORE,
      S_NEXT,
      S_IDLE
   } state_t;

   state_t                 state;
   logic [IdxW-1:0]        channel;
   logic [31:0]            cnt;
   logic [7:0]             sweep;
   logic [NumChannels-1:0] mask;
   logic [31:0]            results [NumChannels];
   logic                   irq_en;
   logic                   sweep_done;

   logic [IdxW-1:0]        next_ch;
   logic [IdxW-1:0]        cand;
   logic                   next_found;
   logic                   sweep_inc;
   logic [63:0]            product;
   logic [31:0]            scaled;
   logic [31:0]            rd_value;
   logic                   unused_wdata;

   assign unused_wdata = ^mm_writedata;

   // Round-robin search for the next enabled channel after the current one.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      next_ch    = channel;
      next_found = 1'b0;
      cand       = '0;
      for (int i = 1; i <= NumChannels; i++) begin
         cand = IdxW'((int'(channel) + i) % NumChannels);
         if (!next_found && mask[cand]) begin
            next_found = 1'b1;
            next_ch    = cand;
         end
      end
      sweep_inc = (state == S_NEXT) && (mask != '0) && (next_ch <= channel);
   end

   // Scale the engine count to Hz, saturating below the "unmeasured" code.
   always_comb begin
      product = 64'(count_in) * 64'(Multiplier);
      scaled  = (product > 64'h0000_0000_FFFF_FFFE) ? 32'hFFFF_FFFE : product[31:0];
   end

   // Measurement sequencer: select, settle, gate, hold, store, advance.
   always_ff @(posedge ref_clk or posedge reset) begin
      // NOTE: sequential state is assigned with <= so every register sees pre-edge values.
      if (reset) begin
         state     <= S_SELECT;
         channel   <= '0;
         probe_sel <= '0;
         gate      <= 1'b0;
         cnt       <= '0;
         sweep     <= '0;
      end else begin
         case (state)
            S_SELECT: begin
               if (cnt == 32'(SettleCycles - 1)) begin
                  state <= S_MEASURE;
                  cnt   <= '0;
                  gate  <= 1'b1;
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end
            S_MEASURE: begin
               if (cnt == 32'(MeasureCycles - 1)) begin
                  state <= S_HOLD;
                  cnt   <= '0;
                  gate  <= 1'b0;
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end
            S_HOLD: begin
               if (cnt == 32'(HoldCycles - 1)) begin
                  state <= S_STORE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end
            S_STORE: state <= S_NEXT;
            S_NEXT: begin
               if (mask == '0) begin
                  state <= S_IDLE;
               end else begin
                  state     <= S_SELECT;
                  channel   <= next_ch;
                  probe_sel <= 4'(next_ch);
                  if (sweep_inc) sweep <= sweep + 8'd1;
               end
            end
            S_IDLE:  if (mask != '0) state <= S_NEXT;
            default: state <= S_IDLE;
         endcase
      end
   end

   // Per-channel result registers, written once per completed window.
   always_ff @(posedge ref_clk or posedge reset) begin
      // NOTE: the result file is small and must read "unmeasured" after reset, so it is reset explicitly.
      if (reset) begin
         for (int i = 0; i < NumChannels; i++) results[i] <= '1;
      end else if (state == S_STORE) begin
         results[channel] <= scaled;
      end
   end

   // Control register and sweep-done flag (set beats a coincident clear).
   always_ff @(posedge ref_clk or posedge reset) begin
      if (reset) begin
         mask       <= '1;
         irq_en     <= 1'b0;
         sweep_done <= 1'b0;
      end else begin
         if (mm_write && mm_address == CtrlAddr) begin
            mask <= mm_writedata[NumChannels-1:0];
`ifdef FREQ_GAUGE_SCHED_IRQ_EN
            irq_en <= mm_writedata[31];
`endif
         end
`ifdef FREQ_GAUGE_SCHED_IRQ_EN
         if (sweep_inc) begin
            sweep_done <= 1'b1;
         end else if (mm_write && mm_address == StatAddr && mm_writedata[30]) begin
            sweep_done <= 1'b0;
         end
`endif
      end
   end

`ifdef FREQ_GAUGE_SCHED_IRQ_EN
   assign irq = sweep_done & irq_en;
`endif

   // Register-map decode from pre-edge state.
   always_comb begin
      rd_value = '0;
      if (mm_address < CtrlAddr) begin
         rd_value = results[mm_address[IdxW-1:0]];
      end else if (mm_address == CtrlAddr) begin
         rd_value[NumChannels-1:0] = mask;
         rd_value[31]              = irq_en;
      end else if (mm_address == StatAddr) begin
         rd_value[7:0]  = sweep;
         rd_value[11:8] = 4'(channel);
         rd_value[30]   = sweep_done;
         rd_value[31]   = (state != S_IDLE);
      end
   end

   // Fixed one-cycle read response.
   always_ff @(posedge ref_clk or posedge reset) begin
      if (reset) begin
         mm_readdata      <= '0;
         mm_readdatavalid <= 1'b0;
      end else begin
         mm_readdatavalid <= mm_read;
         mm_readdata      <= mm_read ? rd_value : '0;
      end
   end

endmodule

// File: tb/tb_freq_gauge_scheduler.sv
// Testbench for freq_gauge_scheduler: random Avalon traffic and count values
// against a procedural reference schedule; read responses go through a
// scoreboard queue, gate/probe_sel are compared every cycle.
module tb_freq_gauge_scheduler;

   localparam int N    = 4;
   localparam int REF  = 10000;
   localparam int MEAS = 100;
   localparam int SET  = 4;
   localparam int HOLD = 8;
   localparam int MUL  = 100;

   logic        ref_clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  probe_sel;
   logic        gate;
   logic [31:0] count_in = 32'd1234;
   logic [3:0]  mm_address = '0;
   logic        mm_read = 1'b0;
   logic        mm_write = 1'b0;
   logic [31:0] mm_writedata = '0;
   logic [31:0] mm_readdata;
   logic        mm_readdatavalid;
`ifdef FREQ_GAUGE_SCHED_IRQ_EN
   logic        irq;
`endif

   freq_gauge_scheduler #(
      .NumChannels(N), .ReferenceClock(REF), .MeasureCycles(MEAS),
      .SettleCycles(SET), .HoldCycles(HOLD), .Multiplier(MUL)
   ) dut (
      .ref_clk(ref_clk), .reset(reset), .probe_sel(probe_sel), .gate(gate),
      .count_in(count_in), .mm_address(mm_address), .mm_read(mm_read),
      .mm_write(mm_write), .mm_writedata(mm_writedata),
      .mm_readdata(mm_readdata), .mm_readdatavalid(mm_readdatavalid)
`ifdef FREQ_GAUGE_SCHED_IRQ_EN
      , .irq(irq)
`endif
   );

   always #5 ref_clk = ~ref_clk;

   int n_compared = 0;
   int n_mismatched = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_compared++;
      if (act !== exp) begin
         n_mismatched++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [31:0] m_res [N];
   logic [3:0]  m_mask, pre_mask, m_sel;
   logic [31:0] cnt_smp;
   logic [7:0]  m_sweep;
   int          m_ch;
   bit          m_busy, m_gate, m_irq_en, m_done;
   logic [31:0] exp_q [$];

   function automatic logic [31:0] sat_hz(input logic [31:0] c);
      logic [63:0] p;
      p = 64'(c) * 64'(MUL);
      return (p > 64'hFFFF_FFFE) ? 32'hFFFF_FFFE : p[31:0];
   endfunction

   function automatic logic [31:0] model_read(input logic [3:0] a);
      if (int'(a) < N) return m_res[int'(a)];
      if (int'(a) == N) return {m_irq_en, 27'b0, m_mask};
      if (int'(a) == N + 1) return {m_busy, m_done, 18'b0, 4'(m_ch), m_sweep};
      return 32'h0;
   endfunction

   // One register-update edge: bus traffic sees pre-edge state.
   task automatic tick();
      @(posedge ref_clk);
      pre_mask = m_mask;
      cnt_smp  = count_in;
      if (reset) return;
      if (mm_read) exp_q.push_back(model_read(mm_address));
      if (mm_write && mm_address == 4'(N)) begin
         m_mask = mm_writedata[3:0];
`ifdef FREQ_GAUGE_SCHED_IRQ_EN
         m_irq_en = mm_writedata[31];
`endif
      end
`ifdef FREQ_GAUGE_SCHED_IRQ_EN
      if (mm_write && mm_address == 4'(N + 1) && mm_writedata[30]) m_done = 1'b0;
`endif
   endtask

   task automatic wait_n(input int n);
      for (int i = 0; i < n; i++) begin
         tick();
         if (reset) return;
      end
   endtask

   task automatic model_run();
      int nxt;
      for (int i = 0; i < N; i++) m_res[i] = 32'hFFFF_FFFF;
      m_mask = 4'hF; pre_mask = 4'hF; m_ch = 0; m_sel = 4'd0; m_sweep = 8'd0;
      m_busy = 1'b1; m_gate = 1'b0; m_irq_en = 1'b0; m_done = 1'b0;
      exp_q.delete();
      forever begin
         wait_n(SET);  if (reset) return;
         m_gate = 1'b1;
         wait_n(MEAS); if (reset) return;
         m_gate = 1'b0;
         wait_n(HOLD); if (reset) return;
         tick();       if (reset) return;
         m_res[m_ch] = sat_hz(cnt_smp);
         forever begin
            tick(); if (reset) return;
            if (pre_mask != 4'd0) break;
            m_busy = 1'b0;
            do begin
               tick(); if (reset) return;
            end while (pre_mask == 4'd0);
            m_busy = 1'b1;
         end
         nxt = -1;
         for (int c = m_ch + 1; c < N; c++) if (pre_mask[c] && nxt < 0) nxt = c;
         if (nxt < 0) begin
            for (int c = 0; c <= m_ch; c++) if (pre_mask[c] && nxt < 0) nxt = c;
            m_sweep = m_sweep + 8'd1;
`ifdef FREQ_GAUGE_SCHED_IRQ_EN
            m_done = 1'b1;
`endif
         end
         m_ch  = nxt;
         m_sel = 4'(nxt);
      end
   endtask

   initial begin : model_proc
      forever begin
         @(negedge reset);
         model_run();
      end
   end

   // ---------------- monitor ----------------
   bit prev_read = 1'b0;

   always @(negedge ref_clk) begin
      if (reset) begin
         check("reset_gate", 32'(gate), 32'd0);
         check("reset_probe_sel", 32'(probe_sel), 32'd0);
         check("reset_rdvalid", 32'(mm_readdatavalid), 32'd0);
         check("reset_rdata", mm_readdata, 32'd0);
         prev_read = 1'b0;
      end else begin
         check("rdvalid_latency", 32'(mm_readdatavalid), 32'(prev_read));
         if (mm_readdatavalid) begin
            if (exp_q.size() == 0) begin
               n_compared++;
               n_mismatched++;
               $display("FAIL readdata: got 0x%08h with no read outstanding", mm_readdata);
            end else begin
               check("readdata", mm_readdata, exp_q.pop_front());
            end
         end
         check("gate", 32'(gate), 32'(m_gate));
         check("probe_sel", 32'(probe_sel), 32'(m_sel));
`ifdef FREQ_GAUGE_SCHED_IRQ_EN
         check("irq", 32'(irq), 32'(m_done & m_irq_en));
`endif
         prev_read = mm_read;
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc(input bit rd, input bit wr, input logic [3:0] a, input logic [31:0] d);
      @(posedge ref_clk);
      #1;
      mm_read = rd; mm_write = wr; mm_address = a; mm_writedata = d;
   endtask

   task automatic rand_cycles(input int n, input bit with_writes);
      int r;
      logic [31:0] d;
      for (int i = 0; i < n; i++) begin
         r = $urandom_range(0, 99);
         if (with_writes && r < 3) begin
            case ($urandom_range(0, 4))
               0: d = 32'hA;
               1: d = 32'h1;
               2: d = 32'h0;
               default: d = $urandom;
            endcase
            cyc(1'($urandom_range(0, 1)), 1'b1, 4'(N), d);
         end else if (with_writes && r < 6) begin
            cyc(1'($urandom_range(0, 1)), 1'b1, 4'($urandom_range(0, 15)), $urandom);
         end else if (r < 45) begin
            cyc(1'b1, 1'b0, 4'($urandom_range(0, 7)), 32'h0);
         end else begin
            cyc(1'b0, 1'b0, 4'h0, 32'h0);
         end
      end
   endtask

   task automatic wait_gate();
      int i;
      cyc(1'b0, 1'b0, 4'h0, 32'h0);
      for (i = 0; i < 400; i++) begin
         @(posedge ref_clk);
         #1;
         if (gate) break;
      end
      if (i == 400) begin
         n_compared++;
         n_mismatched++;
         $display("FAIL wait_gate: gate still 0 after 400 cycles, required 1");
      end
   endtask

   task automatic read_all();
      for (int a = 0; a <= N + 1; a++) cyc(1'b1, 1'b0, 4'(a), 32'h0);
      cyc(1'b0, 1'b0, 4'h0, 32'h0);
   endtask

   // Engine count changes at random moments, biased towards boundary values.
   initial begin : count_proc
      forever begin
         repeat ($urandom_range(40, 180)) @(posedge ref_clk);
         #1;
         case ($urandom_range(0, 6))
            0: count_in = 32'd0;
            1: count_in = 32'd1234;
            2: count_in = 32'h0300_0000;
            3: count_in = 32'd42949672;
            4: count_in = 32'd42949673;
            5: count_in = 32'hFFFF_FFFF;
            default: count_in = $urandom;
         endcase
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      repeat (5) cyc(1'b0, 1'b0, 4'h0, 32'h0);
      reset = 1'b0;
      read_all();
      rand_cycles(250, 1'b0);

      cyc(1'b0, 1'b1, 4'(N), 32'hA);
      rand_cycles(900, 1'b0);

      wait_gate();
      cyc(1'b0, 1'b1, 4'(N), 32'h0);
      rand_cycles(300, 1'b0);
      cyc(1'b0, 1'b1, 4'(N), 32'h1);
      rand_cycles(300, 1'b0);

      cyc(1'b0, 1'b1, 4'(N), 32'h8000_000F);
      rand_cycles(2000, 1'b1);

      cyc(1'b0, 1'b1, 4'(N), 32'hF);
      wait_gate();
      reset = 1'b1;
      #1;
      check("async_reset_gate", 32'(gate), 32'd0);
      repeat (3) cyc(1'b0, 1'b0, 4'h0, 32'h0);
      reset = 1'b0;
      read_all();
      rand_cycles(200, 1'b0);

      repeat (3) cyc(1'b0, 1'b0, 4'h0, 32'h0);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
